// File: rtl/rsa_modexp_param_if.sv
// Host-side bundle for rsa_modexp_param: clock enable, start handshake,
// operands in, busy/eoc/result out.
interface rsa_modexp_param_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             start;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] E;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] Const;
    logic             busy;
    logic             eoc;
    logic [WIDTH-1:0] C;

    modport master (output en, start, P, E, M, Const, input busy, eoc, C);
    modport slave  (input en, start, P, E, M, Const, output busy, eoc, C);
endinterface

// File: rtl/rsa_modexp_param.sv
// C = P^E mod M via bit-serial Montgomery, right-to-left square-and-multiply.
// Define RSA_EARLY_EXIT_EN to stop the exponent loop after the top set bit of E.

// One bit-serial Montgomery lane: one bit of a per cycle, acc holds the partial result.
module rsa_modexp_param_mmm #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           clr,
    input  logic           a_bit,
    input  logic [WIDTH:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0] res
);
    localparam int AW = WIDTH + 3;

    logic [AW-1:0] acc, sum_ab, sum_m, acc_nxt;

    always_comb begin
        sum_ab  = acc + (a_bit ? AW'(b) : '0);
        sum_m   = sum_ab + (sum_ab[0] ? AW'(m) : '0);
        acc_nxt = sum_m >> 1;
    end

    assign res = acc_nxt[WIDTH:0];

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= clr ? '0 : acc_nxt;
    end
endmodule

module rsa_modexp_param #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    rsa_modexp_param_if.slave bus
);
    localparam int N         = WIDTH + 2;
    localparam int CW        = $clog2(N);
    localparam int NUM_LANES = 2;
    localparam int SQ        = 0;
    localparam int MUL       = 1;

    typedef enum logic [2:0] {IDLE, PRE, LOOP, POST, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_r, m_r, k_r, e_sh, c_r;
    logic [WIDTH:0]   pm, rm;
    logic             busy_r, eoc_r;
    logic             last, lane_clr, loop_end, skip_loop;

    logic [NUM_LANES-1:0][N-1:0]   a_word;
    logic [NUM_LANES-1:0][WIDTH:0] lane_b;
    logic [NUM_LANES-1:0][WIDTH:0] lane_res;

    assign last = (cnt == CW'(N - 1));

`ifdef RSA_EARLY_EXIT_EN
    // e_sh has already consumed the bits below the current one
    assign loop_end  = (e_sh[WIDTH-1:1] == '0);
    assign skip_loop = (e_sh == '0);
`else
    localparam int IW = $clog2(WIDTH + 1);
    logic [IW-1:0] iter;

    assign loop_end  = (iter == IW'(WIDTH - 1));
    assign skip_loop = 1'b0;

    always_ff @(posedge clk) begin
        if (rst)
            iter <= '0;
        else if (bus.en) begin
            if (state == IDLE)
                iter <= '0;
            else if (state == LOOP && last)
                iter <= iter + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (bus.en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = PRE;
            PRE:  if (last) state_nxt = skip_loop ? POST : LOOP;
            LOOP: if (last && loop_end) state_nxt = POST;
            POST: if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane operands: PRE converts into Montgomery form, POST converts back out.
    always_comb begin
        a_word[SQ]  = (state == PRE) ? {2'b00, p_r} : {1'b0, pm};
        lane_b[SQ]  = (state == PRE) ? {1'b0, k_r} : pm;
        a_word[MUL] = (state == PRE) ? {2'b00, k_r} : {1'b0, rm};
        lane_b[MUL] = (state == LOOP) ? pm : (WIDTH+1)'(1);
    end

    assign lane_clr = (state != PRE && state != LOOP && state != POST) || last;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        rsa_modexp_param_mmm #(.WIDTH(WIDTH)) u_mmm (
            .clk   (clk),
            .rst   (rst),
            .en    (bus.en),
            .clr   (lane_clr),
            .a_bit (a_word[l][cnt]),
            .b     (lane_b[l]),
            .m     (m_r),
            .res   (lane_res[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            p_r    <= '0;
            m_r    <= '0;
            k_r    <= '0;
            e_sh   <= '0;
            pm     <= '0;
            rm     <= '0;
            c_r    <= '0;
            busy_r <= 1'b0;
            eoc_r  <= 1'b0;
        end else if (bus.en) begin
            eoc_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    p_r    <= bus.P;
                    e_sh   <= bus.E;
                    m_r    <= bus.M;
                    k_r    <= bus.Const;
                    cnt    <= '0;
                    busy_r <= 1'b1;
                end
                PRE, LOOP, POST: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        if (state == PRE) begin
                            pm <= lane_res[SQ];
                            rm <= lane_res[MUL];
                        end else if (state == LOOP) begin
                            pm   <= lane_res[SQ];
                            if (e_sh[0]) rm <= lane_res[MUL];
                            e_sh <= e_sh >> 1;
                        end else begin
                            rm <= lane_res[MUL];
                        end
                    end
                end
                DONE: begin
                    // Output of the final conversion is <= M, so only X == M needs folding
                    c_r    <= (rm == {1'b0, m_r}) ? '0 : rm[WIDTH-1:0];
                    eoc_r  <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.eoc  = eoc_r;
    assign bus.C    = c_r;
endmodule

// File: tb/tb_rsa_modexp_param.sv
// Directed bench for rsa_modexp_param at WIDTH=8, M=187, Const=67.
module tb_rsa_modexp_param;
`ifdef RSA_EARLY_EXIT_EN
    localparam int L_E7  = 51;
    localparam int L_E23 = 71;
    localparam int L_E0  = 21;
    localparam int L_E5  = 51;
`else
    localparam int L_E7  = 101;
    localparam int L_E23 = 101;
    localparam int L_E0  = 101;
    localparam int L_E5  = 101;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    rsa_modexp_param_if #(.WIDTH(8)) bus ();
    rsa_modexp_param #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [7:0] p, input logic [7:0] e);
        bus.P     = p;
        bus.E     = e;
        bus.M     = 8'd187;
        bus.Const = 8'd67;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_eoc(input int from, output int lat, output bit bok);
        lat = from;
        bok = 1'b1;
        while (bus.eoc !== 1'b1 && lat < 400) begin
            if (bus.busy !== 1'b1) bok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic do_run(input string tag, input logic [7:0] p, input logic [7:0] e,
                          input int exp_c, input int exp_lat, input bit chk_drop);
        int lat;
        bit bok;
        launch(p, e);
        wait_eoc(0, lat, bok);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " C"}, 32'(bus.C), exp_c);
        chk({tag, " busy"}, 32'(bok), 1);
        if (chk_drop) begin
            tick();
            chk({tag, " eoc pulse"}, 32'(bus.eoc), 0);
        end
    endtask

    initial begin
        int  lat, n_eoc, n_busy;
        bit  bok, frozen;
        logic       b_snap;
        logic [7:0] c_snap;

        rst = 1'b1;
        bus.en = 1'b1; bus.start = 1'b0;
        bus.P = '0; bus.E = '0; bus.M = '0; bus.Const = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset eoc", 32'(bus.eoc), 0);
        chk("reset C", 32'(bus.C), 0);

        do_run("p88e7", 8'd88, 8'd7, 11, L_E7, 1'b1);
        do_run("p11e23", 8'd11, 8'd23, 88, L_E23, 1'b1);
        // returns in the eoc cycle so the next start is back-to-back
        do_run("p11e0", 8'd11, 8'd0, 1, L_E0, 1'b0);
        do_run("p0e5 b2b", 8'd0, 8'd5, 0, L_E5, 1'b1);

        // start pulse and operand changes while busy are ignored
        launch(8'd88, 8'd7);
        repeat (30) tick();
        bus.P = 8'd11; bus.E = 8'd23; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_eoc(31, lat, bok);
        chk("midstart latency", lat, L_E7);
        chk("midstart C", 32'(bus.C), 11);
        chk("midstart busy", 32'(bok), 1);
        n_eoc = 0; n_busy = 0;
        repeat (120) begin
            tick();
            if (bus.eoc === 1'b1) n_eoc++;
            if (bus.busy === 1'b1) n_busy++;
        end
        chk("midstart extra eoc", n_eoc, 0);
        chk("midstart restart busy", n_busy, 0);

        // reset mid-run
        launch(8'd88, 8'd7);
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort eoc", 32'(bus.eoc), 0);
        chk("abort C", 32'(bus.C), 0);
        n_eoc = 0;
        repeat (120) begin
            tick();
            if (bus.eoc === 1'b1) n_eoc++;
        end
        chk("abort no eoc", n_eoc, 0);
        do_run("after abort", 8'd88, 8'd7, 11, L_E7, 1'b1);

        // clock enable low for 17 cycles
        launch(8'd88, 8'd7);
        repeat (30) tick();
        b_snap = bus.busy; c_snap = bus.C;
        bus.en = 1'b0;
        frozen = 1'b1;
        repeat (17) begin
            tick();
            if (bus.busy !== b_snap || bus.eoc !== 1'b0 || bus.C !== c_snap) frozen = 1'b0;
        end
        bus.en = 1'b1;
        wait_eoc(47, lat, bok);
        chk("en-low latency", lat, L_E7 + 17);
        chk("en-low C", 32'(bus.C), 11);
        chk("en-low frozen", 32'(frozen), 1);
        chk("en-low busy", 32'(bok), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
